// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths and read-owner encoding for the memory arbiter
package mem_arbiter_pkg;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_STREAK = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_inst_req,
  input  logic [31:0]           i_inst_addr,
  output logic                  o_inst_gnt,
  output logic                  o_inst_rvalid,
  output logic [DATA_WIDTH-1:0] o_inst_rdata,
  input  logic                  i_data_req,
  input  logic                  i_data_we,
  input  logic [3:0]            i_data_be,
  input  logic [31:0]           i_data_addr,
  input  logic [DATA_WIDTH-1:0] i_data_wdata,
  output logic                  o_data_gnt,
  output logic                  o_data_rvalid,
  output logic [DATA_WIDTH-1:0] o_data_rdata,
  output logic                  o_mem_en,
  output logic [3:0]            o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);
  localparam int SW = MAX_STREAK > 0 ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(MAX_STREAK);
  owner_e owner, owner_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic inst_gnt, data_gnt;
  logic unused_addr;
  assign unused_addr = ^{i_inst_addr[1:0], i_inst_addr[31:ADDR_WIDTH+2],
                         i_data_addr[1:0], i_data_addr[31:ADDR_WIDTH+2]};
  // data wins ties until fetch has been passed over MAX_STREAK times in a row
  always_comb begin
    data_gnt = !rst && i_data_req && !(i_inst_req && streak == SMAX);
    inst_gnt = !rst && i_inst_req && !data_gnt;
    streak_nxt = (inst_gnt || !i_inst_req) ? '0 :
                 (data_gnt && streak != SMAX) ? streak + SW'(1) : streak;
    owner_nxt = inst_gnt ? OWN_INST : (data_gnt && !i_data_we) ? OWN_DATA : OWN_NONE;
  end
  // owner remembers who gets next cycle's RAM read data; streak counts fetch waits
  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= OWN_NONE;
      streak <= '0;
    end else begin
      owner  <= owner_nxt;
      streak <= streak_nxt;
    end
  end
  assign o_inst_gnt    = inst_gnt;
  assign o_data_gnt    = data_gnt;
  assign o_mem_en      = inst_gnt || data_gnt;
  assign o_mem_we      = (data_gnt && i_data_we) ? i_data_be : 4'b0;
  assign o_mem_addr    = data_gnt ? i_data_addr[ADDR_WIDTH+1:2] :
                         inst_gnt ? i_inst_addr[ADDR_WIDTH+1:2] : '0;
  assign o_mem_wdata   = data_gnt ? i_data_wdata : '0;
  assign o_inst_rvalid = !rst && owner == OWN_INST;
  assign o_data_rvalid = !rst && owner == OWN_DATA;
  assign o_inst_rdata  = i_mem_rdata;
  assign o_data_rdata  = i_mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table, directed and random checks of mem_arbiter against a reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int MS = 2;
  logic clk = 0;
  logic rst = 1;
  logic i_inst_req = 0, i_data_req = 0, i_data_we = 0;
  logic [31:0] i_inst_addr = 0, i_data_addr = 0, i_data_wdata = 0, i_mem_rdata;
  logic [3:0] i_data_be = 0;
  logic o_inst_gnt, o_inst_rvalid, o_data_gnt, o_data_rvalid, o_mem_en;
  logic [31:0] o_inst_rdata, o_data_rdata, o_mem_wdata;
  logic [3:0] o_mem_we;
  logic [11:0] o_mem_addr;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_STREAK(MS)) dut (
    .clk(clk), .rst(rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr), .o_inst_gnt(o_inst_gnt),
    .o_inst_rvalid(o_inst_rvalid), .o_inst_rdata(o_inst_rdata),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_be(i_data_be),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata), .o_data_gnt(o_data_gnt),
    .o_data_rvalid(o_data_rvalid), .o_data_rdata(o_data_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );
  // environment RAM: single port, one-cycle read latency, byte-enabled writes
  logic [31:0] ram [4096];
  logic init_ram = 1;
  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 4096; i++) ram[i] <= i * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    end else if (o_mem_en) begin
      if (o_mem_we == 4'b0) i_mem_rdata <= ram[o_mem_addr];
      for (int b = 0; b < 4; b++) if (o_mem_we[b]) ram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
  end
  logic [31:0] ref_mem [4096];
  int checks = 0, errors = 0;
  int m_wait = 0, pend = 0;
  logic [31:0] pend_data;
  logic act_gi, act_gd;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // one clock of stimulus; the model predicts grants, RAM strobes and read returns
  task automatic cycle(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [3:0] be, input logic [31:0] da, input logic [31:0] dd);
    logic gd, gi;
    int wa;
    @(posedge clk);
    #1;
    rst = r; i_inst_req = ir; i_inst_addr = ia; i_data_req = dr;
    i_data_we = dw; i_data_be = be; i_data_addr = da; i_data_wdata = dd;
    gd = !r && dr && !(ir && m_wait == MS);
    gi = !r && ir && !gd;
    wa = gd ? int'((da >> 2) % 4096) : gi ? int'((ia >> 2) % 4096) : 0;
    #3;
    chk("inst_gnt", 32'(o_inst_gnt), 32'(gi));
    chk("data_gnt", 32'(o_data_gnt), 32'(gd));
    chk("mem_en", 32'(o_mem_en), 32'(gi || gd));
    chk("mem_we", 32'(o_mem_we), (gd && dw) ? 32'(be) : 32'd0);
    if (gi || gd || r) chk("mem_addr", 32'(o_mem_addr), 32'(wa));
    if (gd || r) chk("mem_wdata", o_mem_wdata, r ? 32'd0 : dd);
    chk("inst_rvalid", 32'(o_inst_rvalid), 32'(!r && pend == 1));
    chk("data_rvalid", 32'(o_data_rvalid), 32'(!r && pend == 2));
    if (!r && pend == 1) chk("inst_rdata", o_inst_rdata, pend_data);
    if (!r && pend == 2) chk("data_rdata", o_data_rdata, pend_data);
    act_gi = o_inst_gnt;
    act_gd = o_data_gnt;
    if (r) begin
      pend = 0;
      m_wait = 0;
    end else begin
      pend = gi ? 1 : (gd && !dw) ? 2 : 0;
      pend_data = ref_mem[wa];
      if (gd && dw) for (int b = 0; b < 4; b++) if (be[b]) ref_mem[wa][8*b +: 8] = dd[8*b +: 8];
      m_wait = (gi || !ir) ? 0 : gd ? (m_wait < MS ? m_wait + 1 : MS) : m_wait;
    end
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 4'h0, 0, 0);
  endtask
  typedef struct {
    logic ir; logic [31:0] ia; logic dr, dw; logic [3:0] be; logic [31:0] da, dd;
    logic egi, egd; logic [11:0] eaddr; logic [3:0] ewe;
  } vec_t;
  vec_t tbl [9];
  string pat;
  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = i * 32'h9E37_79B1 ^ 32'h5A5A_0000;
    tbl[0] = '{0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 12'h000, 4'h0};
    tbl[1] = '{1, 32'h10,        0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 12'h004, 4'h0};
    tbl[2] = '{1, 32'h4004,      0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 12'h001, 4'h0};
    tbl[3] = '{0, 32'h0,         1, 0, 4'h0, 32'h20,        32'h0,         0, 1, 12'h008, 4'h0};
    tbl[4] = '{0, 32'h0,         1, 1, 4'h3, 32'h20,        32'hDEADBEEF,  0, 1, 12'h008, 4'h3};
    tbl[5] = '{1, 32'h10,        1, 0, 4'h0, 32'h24,        32'h0,         0, 1, 12'h009, 4'h0};
    tbl[6] = '{1, 32'h10,        1, 0, 4'h0, 32'h24,        32'h0,         0, 1, 12'h009, 4'h0};
    tbl[7] = '{1, 32'h10,        1, 0, 4'h0, 32'h24,        32'h0,         1, 0, 12'h004, 4'h0};
    tbl[8] = '{0, 32'h0,         1, 1, 4'h8, 32'hFFFF_FFFD, 32'h7700_0000, 0, 1, 12'hFFF, 4'h8};
    cycle(1, 1, 32'h10, 1, 1, 4'hF, 32'h20, 32'hAAAA_5555);
    cycle(1, 1, 32'h10, 1, 0, 4'hF, 32'h20, 32'hAAAA_5555);
    init_ram = 0;
    for (int k = 0; k < 9; k++) begin
      cycle(0, tbl[k].ir, tbl[k].ia, tbl[k].dr, tbl[k].dw, tbl[k].be, tbl[k].da, tbl[k].dd);
      chk($sformatf("tbl%0d_gi", k), 32'(o_inst_gnt), 32'(tbl[k].egi));
      chk($sformatf("tbl%0d_gd", k), 32'(o_data_gnt), 32'(tbl[k].egd));
      if (tbl[k].egi || tbl[k].egd) chk($sformatf("tbl%0d_addr", k), 32'(o_mem_addr), 32'(tbl[k].eaddr));
      chk($sformatf("tbl%0d_we", k), 32'(o_mem_we), 32'(tbl[k].ewe));
    end
    idle();
    cycle(0, 0, 0, 1, 1, 4'hF, 32'h10, 32'h0000_0013);
    cycle(0, 1, 32'h10, 0, 0, 4'h0, 0, 0);
    chk("fetch_gnt", 32'(o_inst_gnt), 32'd1);
    chk("fetch_addr", 32'(o_mem_addr), 32'd4);
    idle();
    chk("fetch_rvalid", 32'(o_inst_rvalid), 32'd1);
    chk("fetch_rdata", o_inst_rdata, 32'h0000_0013);
    cycle(0, 0, 0, 1, 1, 4'hF, 32'h20, 32'h1111_1111);
    cycle(0, 0, 0, 1, 1, 4'h3, 32'h20, 32'hDEAD_BEEF);
    cycle(0, 0, 0, 1, 0, 4'h0, 32'h20, 0);
    chk("write_no_rvalid", 32'(o_data_rvalid), 32'd0);
    idle();
    chk("readback_rvalid", 32'(o_data_rvalid), 32'd1);
    chk("readback_rdata", o_data_rdata, 32'h1111_BEEF);
    idle();
    pat = "";
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1, 32'h10, 1, 0, 4'h0, 32'h24, 0);
      pat = {pat, act_gd ? "D" : act_gi ? "I" : "-"};
    end
    checks++;
    if (pat != "DDIDDI") begin
      errors++;
      $display("FAIL starve_pattern: got %s expected DDIDDI", pat);
    end
    idle();
    cycle(0, 1, 32'h10, 0, 0, 4'h0, 0, 0);
    cycle(1, 1, 32'h10, 1, 1, 4'hF, 32'h20, 32'hFFFF_FFFF);
    chk("rst_no_rvalid", 32'(o_inst_rvalid), 32'd0);
    chk("rst_en", 32'(o_mem_en), 32'd0);
    chk("rst_gnt", 32'({o_inst_gnt, o_data_gnt}), 32'd0);
    cycle(0, 1, 32'h10, 0, 0, 4'h0, 0, 0);
    chk("post_rst_gnt", 32'(o_inst_gnt), 32'd1);
    idle();
    chk("post_rst_rdata", o_inst_rdata, 32'h0000_0013);
    cycle(0, 1, 32'h0000_4004, 0, 0, 4'h0, 0, 0);
    chk("wrap_addr", 32'(o_mem_addr), 32'd1);
    for (int k = 0; k < 100; k++) begin
      if (k % 2 == 0) cycle(0, 1, 32'($urandom_range(0, 63)) << 2, 0, 0, 4'h0, 0, 0);
      else cycle(0, 0, 0, 1, 0, 4'h0, 32'($urandom_range(0, 63)) << 2, 0);
    end
    for (int k = 0; k < 400; k++) begin
      cycle(0, 1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 31)) << 2),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 31)) << 2), $urandom);
    end
    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameters: ADDR_WIDTH, default 12, RAM word-address width (4096 words); DATA_WIDTH, default 32, data/instruction width; MAX_STREAK, default 2, consecutive data grants allowed while fetch waits.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have fetch ports: i_inst_req in 1 fetch request; i_inst_addr in 32 byte address; o_inst_gnt out 1 request accepted this cycle; o_inst_rvalid out 1 fetch data valid; o_inst_rdata out DATA_WIDTH instruction.
REQ-004 SHALL have load/store ports: i_data_req in 1 request; i_data_we in 1 write; i_data_be in 4 byte enables; i_data_addr in 32 byte address; i_data_wdata in DATA_WIDTH write data; o_data_gnt out 1 accepted; o_data_rvalid out 1 load data valid; o_data_rdata out DATA_WIDTH load data.
REQ-005 SHALL have RAM ports: o_mem_en out 1 access strobe; o_mem_we out 4 byte write enables; o_mem_addr out ADDR_WIDTH word address; o_mem_wdata out DATA_WIDTH; i_mem_rdata in DATA_WIDTH, valid one cycle after a read strobe.

Function
REQ-006 SHALL share one single-port, 1-cycle-latency synchronous RAM between fetch and load/store, with at most one access per cycle.
REQ-007 SHALL grant combinationally in the request cycle: at most one of o_inst_gnt/o_data_gnt high; a grant is issued only to an asserted request.
REQ-008 SHALL default to data priority when both requests are asserted, unless streak == MAX_STREAK, in which case fetch is granted.
REQ-009 SHALL keep a streak counter (0..MAX_STREAK): +1 when data is granted while i_inst_req is high; cleared when fetch is granted or i_inst_req is low; saturates at MAX_STREAK.
REQ-010 SHALL drive the RAM in the grant cycle: o_mem_en=1; o_mem_addr=addr[ADDR_WIDTH+1:2]; o_mem_we=i_data_be if data write, else 0; o_mem_wdata=i_data_wdata. Address bits [1:0] and bits above ADDR_WIDTH+1 are ignored (wrap).
REQ-011 SHALL track the read owner in a registered state owner in {OWN_NONE, OWN_INST, OWN_DATA}: next = OWN_INST on fetch grant, OWN_DATA on data read grant, else OWN_NONE (data writes included).
REQ-012 SHALL assert o_inst_rvalid when owner==OWN_INST and o_data_rvalid when owner==OWN_DATA, exactly one cycle after the grant, with rdata = i_mem_rdata; each rvalid is a single-cycle pulse per grant.
REQ-013 SHALL produce no rvalid for writes; a write's data is visible to a read granted in the next cycle.
REQ-014 SHALL support back-to-back grants every cycle, including alternating requesters, without bubbles.
REQ-015 SHALL drive o_mem_en=0, o_mem_we=0, both gnt=0 when no request is asserted; o_inst_rdata/o_data_rdata always mirror i_mem_rdata.
REQ-016 SHALL require requesters to hold req/addr/data stable until granted; a request deasserted before grant is dropped silently.

Reset
REQ-017 SHALL, while rst=1, force o_inst_gnt=0, o_data_gnt=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, owner=OWN_NONE, streak=0.
REQ-018 SHALL, when rst asserts one cycle after a read grant, return owner=OWN_NONE on the next edge and suppress that read's rvalid (the read is discarded).
REQ-019 SHALL accept requests in the first cycle after rst deasserts.

Structure
REQ-020 SHALL place the owner_e enum (OWN_NONE, OWN_INST, OWN_DATA) and the default DATA_WIDTH/ADDR_WIDTH constants in the shared core package.
REQ-021 SHALL have no sub-module; the priority and streak logic SHALL be inline, with only owner and streak registered.

Verification
REQ-022 SHALL cover an isolated fetch: inst_req, addr 0x0000_0010, RAM word 4 = 0x0000_0013 -> gnt same cycle, o_mem_addr=4, next cycle o_inst_rvalid=1, o_inst_rdata=0x0000_0013.
REQ-023 SHALL cover a write then read-back: data write addr 0x20, be=4'b0011, wdata 0xDEAD_BEEF over 0x1111_1111, then read 0x20 -> o_data_rdata=0x1111_BEEF, no rvalid for the write.
REQ-024 SHALL cover starvation with both requests held continuously (MAX_STREAK=2) -> grant pattern D,D,I,D,D,I; fetch waits at most 2 cycles.
REQ-025 SHALL cover reset one cycle after a fetch grant -> no o_inst_rvalid, all outputs 0, and a fetch granted in the first cycle after reset release.
REQ-026 SHALL cover address wrap: fetch addr 0x0000_4004 with ADDR_WIDTH=12 -> o_mem_addr=1.
REQ-027 SHALL cover alternating fetch/load every cycle for 100 cycles -> one rvalid per read grant, routed to the correct port, against a reference memory model.
